replay_task_decoder: RTL and testbench
======================================

Name: replay_task_decoder

Overview:
- Parametrised successor to the command-stream decoder between the command FIFO and the RS / memory-request arbiter.
- Decodes 2-bit-opcode command packets: task dispatch, replay-iteration barrier, feature-vector count, weight boundary.
- Generalised in iteration count, PE/bank count and field widths.
- Adds valid/ready backpressure on input and RS output, arbitrated memory issue for replay packets, and a saturating deferred-task counter.

Parameters:
PKT_W, 32, command packet width; opcode = bits [PKT_W-1:PKT_W-2]
NUM_ITER, 4, replay iterations; last iteration index = NUM_ITER-1
ITER_LSB, 10, LSB of the NUM_ITER-bit iteration mask in a task packet
NUM_PE, 4, edge PEs monitored for idle
NUM_BANK, 4, memory banks monitored for busy
FV_W, 5, Num_FV field width (packet bits [FV_W-1:0])
WB_W, 4, weight-boundary field width (packet bits [WB_W-1:0])
CNT_W, 16, deferred-task counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset (0 = reset)
in_valid  in  1  command packet valid
in_pkt  in  PKT_W  command packet
in_ready  out  1  packet accepted when in_valid&in_ready
rs_valid  out  1  task to RS valid (registered)
rs_pkt  out  PKT_W-2  task payload (opcode stripped)
rs_ready  in  1  RS accepts
RS_empty  in  1  RS holds no tasks
PE_IDLE  in  NUM_PE  per-PE idle
bank_busy_in  in  NUM_BANK  per-bank busy
Req  out  1  memory-arbiter request (registered)
grant  in  1  arbiter grant
mem_valid  out  1  one-cycle memory packet strobe
mem_pkt  out  PKT_W  full packet to memory
stream_begin  out  1  one-cycle pulse after Num_FV load
stream_end  in  1  weight/feature stream finished
vertex_done  in  1  final vertex update complete
cntl_done  out  1  one-cycle pulse: last-iteration barrier reached
task_complete  out  1  sticky: all work done
replay_Iter  out  $clog2(NUM_ITER)  current iteration
Num_FV  out  FV_W  registered feature-vector count
Weights_boundary  out  WB_W  registered weight boundary
defer_cnt  out  CNT_W  saturating count of tasks sent to memory

Behaviour:
- Reset (reset==0, async): state IDLE; all outputs and registers 0; task_complete cleared. Mid-operation reset aborts everything, including a pending Req.
- States: IDLE, MEM_REQ, DRAIN, REPLAY_REQ, WAIT_STREAM, DONE.
- in_ready = (state==IDLE) && (!rs_valid || rs_ready); 0 in every other state.
- On accept in IDLE, by opcode:
  - 00 task, mask = in_pkt[ITER_LSB +: NUM_ITER]:
    - mask[replay_Iter]==1: rs_pkt <= payload, rs_valid <= 1 next cycle; rs_valid holds until rs_ready. Back-to-back: full throughput when rs_ready stays 1.
    - Otherwise: latch packet, Req <= 1, go MEM_REQ; defer_cnt++ (saturate at all-ones).
  - 01 replay: latch packet, go DRAIN.
  - 10: Num_FV <= in_pkt[FV_W-1:0]; stream_begin pulses the following cycle; stay IDLE.
  - 11: Weights_boundary <= in_pkt[WB_W-1:0]; go WAIT_STREAM.
- MEM_REQ: when grant && Req: mem_valid=1 and mem_pkt=latched packet for that cycle, Req <= 0, go IDLE. grant while Req==0 is ignored.
- DRAIN: drained = !(|bank_busy_in) && RS_empty && (&PE_IDLE) && !rs_valid.
  - drained && replay_Iter==NUM_ITER-1: cntl_done pulse, go DONE.
  - drained otherwise: Req <= 1, go REPLAY_REQ.
- REPLAY_REQ: on grant, issue mem_valid/mem_pkt, replay_Iter++, Req <= 0, go WAIT_STREAM.
- WAIT_STREAM: on stream_end go IDLE. If stream_end arrives in the same cycle as state entry, it is not seen; it is sampled from the first cycle in state.
- DONE: in_ready=0. On vertex_done, task_complete <= 1 and holds until reset. No exit except reset.
- replay_Iter never wraps; the last-iteration branch prevents the increment.
- Simultaneous events:
  - A 10 opcode never coincides with a stream_begin that is still pending.
  - rs_ready with no rs_valid has no effect.

Decomposition:
- decoder_pkg: opcode enum (OP_TASK, OP_REPLAY, OP_NUMFV, OP_WBOUND), state enum, default field-position localparams.
- One natural sub-module, rs_out_reg: one-entry valid/ready output register for the RS path.

Test Plan:
- Task packet with mask 4'b0001 at iter 0, rs_ready=1 → rs_valid the next cycle with the payload; three back-to-back tasks → three consecutive rs_valid cycles.
- Task with mask 4'b0010 at iter 0 → Req=1, in_ready=0; grant after 3 cycles → one mem_valid with the packet, Req=0, defer_cnt=1.
- Replay packet with PE_IDLE=4'b0111 → stays in DRAIN. All idle → Req, then grant → mem_valid, replay_Iter=1, in_ready=0 until stream_end.
- Replay at replay_Iter=3 (NUM_ITER=4), drained → cntl_done for one cycle, no Req. vertex_done → task_complete=1 and held.
- Opcode 10 with payload 5'd9 → Num_FV=9, stream_begin pulse one cycle later. Opcode 11 with 4'd6 → Weights_boundary=6, in_ready=0 until stream_end.
- reset=0 asserted asynchronously while Req=1 in REPLAY_REQ → all outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/replay_task_decoder_pkg.sv
// replay_task_decoder_pkg: opcodes, FSM state encodings and default field positions
package replay_task_decoder_pkg;

    typedef enum logic [1:0] {
        OP_TASK   = 2'b00,
        OP_REPLAY = 2'b01,
        OP_NUMFV  = 2'b10,
        OP_WBOUND = 2'b11
    } opcode_e;

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_MEM_REQ     = 3'd1;
    localparam logic [2:0] S_DRAIN       = 3'd2;
    localparam logic [2:0] S_REPLAY_REQ  = 3'd3;
    localparam logic [2:0] S_WAIT_STREAM = 3'd4;
    localparam logic [2:0] S_DONE        = 3'd5;

    localparam int DEF_PKT_W    = 32;
    localparam int DEF_NUM_ITER = 4;
    localparam int DEF_ITER_LSB = 10;
    localparam int DEF_NUM_PE   = 4;
    localparam int DEF_NUM_BANK = 4;
    localparam int DEF_FV_W     = 5;
    localparam int DEF_WB_W     = 4;
    localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/replay_task_decoder_rs_out_reg.sv
// rs_out_reg: one-entry valid/ready holding register for tasks headed to the RS
module rs_out_reg #(
    parameter int W = 30
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);

    // load only happens when the slot is empty or draining, so it always wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/replay_task_decoder.sv
// replay_task_decoder: command-stream decoder feeding the RS and the memory-request arbiter
module replay_task_decoder
    import replay_task_decoder_pkg::*;
#(
    parameter int PKT_W    = DEF_PKT_W,
    parameter int NUM_ITER = DEF_NUM_ITER,
    parameter int ITER_LSB = DEF_ITER_LSB,
    parameter int NUM_PE   = DEF_NUM_PE,
    parameter int NUM_BANK = DEF_NUM_BANK,
    parameter int FV_W     = DEF_FV_W,
    parameter int WB_W     = DEF_WB_W,
    parameter int CNT_W    = DEF_CNT_W,
    localparam int IW      = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [PKT_W-1:0]    in_pkt,
    output logic                in_ready,
    output logic                rs_valid,
    output logic [PKT_W-3:0]    rs_pkt,
    input  logic                rs_ready,
    input  logic                RS_empty,
    input  logic [NUM_PE-1:0]   PE_IDLE,
    input  logic [NUM_BANK-1:0] bank_busy_in,
    output logic                Req,
    input  logic                grant,
    output logic                mem_valid,
    output logic [PKT_W-1:0]    mem_pkt,
    output logic                stream_begin,
    input  logic                stream_end,
    input  logic                vertex_done,
    output logic                cntl_done,
    output logic                task_complete,
    output logic [IW-1:0]       replay_Iter,
    output logic [FV_W-1:0]     Num_FV,
    output logic [WB_W-1:0]     Weights_boundary,
    output logic [CNT_W-1:0]    defer_cnt
);

    logic [2:0]          state;
    logic [PKT_W-1:0]    pkt_q;
    logic [NUM_ITER-1:0] mask;
    opcode_e             op;
    logic                accept;
    logic                hit;
    logic                last_iter;
    logic                drained;
    logic                rs_load;

    // decode of the packet on the input port and drain/issue conditions
    always_comb begin
        op        = opcode_e'(in_pkt[PKT_W-1 -: 2]);
        mask      = in_pkt[ITER_LSB +: NUM_ITER];
        hit       = mask[replay_Iter];
        last_iter = replay_Iter == IW'(NUM_ITER - 1);
        in_ready  = reset && (state == S_IDLE) && (!rs_valid || rs_ready);
        accept    = in_valid && in_ready;
        rs_load   = accept && (op == OP_TASK) && hit;
        drained   = !(|bank_busy_in) && RS_empty && (&PE_IDLE) && !rs_valid;
        mem_valid = grant && Req;
        mem_pkt   = mem_valid ? pkt_q : '0;
    end

    rs_out_reg #(.W(PKT_W - 2)) u_rs_out (
        .clk   (clk),
        .reset (reset),
        .load  (rs_load),
        .din   (in_pkt[PKT_W-3:0]),
        .ready (rs_ready),
        .valid (rs_valid),
        .data  (rs_pkt)
    );

    // control FSM: dispatch, deferral to memory, replay barrier and stream waits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            pkt_q            <= '0;
            Req              <= 1'b0;
            stream_begin     <= 1'b0;
            cntl_done        <= 1'b0;
            task_complete    <= 1'b0;
            replay_Iter      <= '0;
            Num_FV           <= '0;
            Weights_boundary <= '0;
            defer_cnt        <= '0;
        end else begin
            stream_begin <= accept && (op == OP_NUMFV);
            cntl_done    <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    case (op)
                        OP_TASK: if (!hit) begin
                            pkt_q <= in_pkt;
                            Req   <= 1'b1;
                            state <= S_MEM_REQ;
                            if (!(&defer_cnt)) defer_cnt <= defer_cnt + CNT_W'(1);
                        end
                        OP_REPLAY: begin
                            pkt_q <= in_pkt;
                            state <= S_DRAIN;
                        end
                        OP_NUMFV: Num_FV <= in_pkt[FV_W-1:0];
                        default: begin
                            Weights_boundary <= in_pkt[WB_W-1:0];
                            state            <= S_WAIT_STREAM;
                        end
                    endcase
                end
                S_MEM_REQ: if (grant && Req) begin
                    Req   <= 1'b0;
                    state <= S_IDLE;
                end
                S_DRAIN: if (drained) begin
                    if (last_iter) begin
                        cntl_done <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        Req   <= 1'b1;
                        state <= S_REPLAY_REQ;
                    end
                end
                S_REPLAY_REQ: if (grant && Req) begin
                    Req         <= 1'b0;
                    replay_Iter <= replay_Iter + IW'(1);
                    state       <= S_WAIT_STREAM;
                end
                S_WAIT_STREAM: if (stream_end) state <= S_IDLE;
                S_DONE: if (vertex_done) task_complete <= 1'b1;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_replay_task_decoder.sv
// tb_replay_task_decoder: directed self-checking bench for replay_task_decoder
module tb_replay_task_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pkt;
    logic        in_ready;
    logic        rs_valid;
    logic [29:0] rs_pkt;
    logic        rs_ready;
    logic        RS_empty;
    logic [3:0]  PE_IDLE;
    logic [3:0]  bank_busy_in;
    logic        Req;
    logic        grant;
    logic        mem_valid;
    logic [31:0] mem_pkt;
    logic        stream_begin;
    logic        stream_end;
    logic        vertex_done;
    logic        cntl_done;
    logic        task_complete;
    logic [1:0]  replay_Iter;
    logic [4:0]  Num_FV;
    logic [3:0]  Weights_boundary;
    logic [15:0] defer_cnt;

    int checks = 0;
    int failures = 0;

    replay_task_decoder dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_pkt           (in_pkt),
        .in_ready         (in_ready),
        .rs_valid         (rs_valid),
        .rs_pkt           (rs_pkt),
        .rs_ready         (rs_ready),
        .RS_empty         (RS_empty),
        .PE_IDLE          (PE_IDLE),
        .bank_busy_in     (bank_busy_in),
        .Req              (Req),
        .grant            (grant),
        .mem_valid        (mem_valid),
        .mem_pkt          (mem_pkt),
        .stream_begin     (stream_begin),
        .stream_end       (stream_end),
        .vertex_done      (vertex_done),
        .cntl_done        (cntl_done),
        .task_complete    (task_complete),
        .replay_Iter      (replay_Iter),
        .Num_FV           (Num_FV),
        .Weights_boundary (Weights_boundary),
        .defer_cnt        (defer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_replay(input logic [31:0] p, input logic [1:0] exp_iter);
        in_valid = 1'b1;
        in_pkt   = p;
        tick();
        in_valid = 1'b0;
        check("rp_drain_ready", in_ready, 0);
        tick();
        check("rp_req", Req, 1);
        grant = 1'b1;
        #1;
        check("rp_mem_valid", mem_valid, 1);
        check("rp_mem_pkt", mem_pkt, p);
        tick();
        grant = 1'b0;
        check("rp_req_clr", Req, 0);
        check("rp_iter", replay_Iter, exp_iter);
        check("rp_wait_ready", in_ready, 0);
        stream_end = 1'b1;
        tick();
        stream_end = 1'b0;
        check("rp_idle_ready", in_ready, 1);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_pkt = '0; rs_ready = 1'b1;
        RS_empty = 1'b1; PE_IDLE = 4'hF; bank_busy_in = 4'h0;
        grant = 1'b0; stream_end = 1'b0; vertex_done = 1'b0;
        tick(); tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_rs_valid", rs_valid, 0);
        check("rst_req", Req, 0);
        check("rst_defer", defer_cnt, 0);
        check("rst_iter", replay_Iter, 0);
        reset = 1'b1;
        #1;
        check("post_rst_ready", in_ready, 1);

        // dispatch at iteration 0 (mask bit 0), then back-to-back
        in_valid = 1'b1; in_pkt = 32'h0000_05A5;
        tick();
        check("t0_valid", rs_valid, 1);
        check("t0_pkt", rs_pkt, 30'h5A5);
        in_pkt = 32'h0000_0FF1;
        tick();
        check("t1_pkt", rs_pkt, 30'hFF1);
        in_pkt = 32'h0000_3C07;
        tick();
        check("t2_valid", rs_valid, 1);
        check("t2_pkt", rs_pkt, 30'h3C07);
        in_valid = 1'b0;
        tick();
        check("t_idle_valid", rs_valid, 0);

        // RS backpressure holds the entry and blocks input
        rs_ready = 1'b0; in_valid = 1'b1; in_pkt = 32'h0000_0412;
        tick();
        in_valid = 1'b0;
        check("bp_valid", rs_valid, 1);
        check("bp_ready", in_ready, 0);
        tick();
        check("bp_hold", rs_pkt, 30'h412);
        rs_ready = 1'b1;
        tick();
        check("bp_release", rs_valid, 0);

        // deferred task: mask 0010 at iteration 0
        in_valid = 1'b1; in_pkt = 32'h0000_080F;
        tick();
        in_valid = 1'b0;
        check("df_req", Req, 1);
        check("df_ready", in_ready, 0);
        check("df_cnt", defer_cnt, 1);
        check("df_no_rs", rs_valid, 0);
        tick(); tick(); tick();
        check("df_wait_mv", mem_valid, 0);
        grant = 1'b1;
        #1;
        check("df_mem_valid", mem_valid, 1);
        check("df_mem_pkt", mem_pkt, 32'h0000_080F);
        tick();
        check("df_req_clr", Req, 0);
        check("df_grant_ignored", mem_valid, 0);
        check("df_idle_ready", in_ready, 1);
        grant = 1'b0;

        // feature-vector count
        in_valid = 1'b1; in_pkt = 32'h8000_0009;
        tick();
        in_valid = 1'b0;
        check("fv_val", Num_FV, 9);
        check("fv_begin", stream_begin, 1);
        tick();
        check("fv_begin_end", stream_begin, 0);

        // weight boundary
        in_valid = 1'b1; in_pkt = 32'hC000_0006;
        tick();
        in_valid = 1'b0;
        check("wb_val", Weights_boundary, 6);
        check("wb_ready", in_ready, 0);
        tick();
        check("wb_hold", in_ready, 0);
        stream_end = 1'b1;
        tick();
        stream_end = 1'b0;
        check("wb_done", in_ready, 1);

        // stream_end on the entry cycle is not seen
        stream_end = 1'b1; in_valid = 1'b1; in_pkt = 32'hC000_0003;
        tick();
        in_valid = 1'b0;
        check("wb2_val", Weights_boundary, 3);
        check("wb2_entry", in_ready, 0);
        tick();
        stream_end = 1'b0;
        check("wb2_exit", in_ready, 1);

        // replay with one PE busy stays in drain
        PE_IDLE = 4'b0111; in_valid = 1'b1; in_pkt = 32'h4000_0123;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check("dr_req", Req, 0);
        check("dr_ready", in_ready, 0);
        PE_IDLE = 4'hF;
        tick();
        check("dr_req1", Req, 1);
        grant = 1'b1;
        #1;
        check("dr_mem_pkt", mem_pkt, 32'h4000_0123);
        tick();
        grant = 1'b0;
        check("dr_iter", replay_Iter, 1);
        check("dr_wait", in_ready, 0);
        stream_end = 1'b1;
        tick();
        stream_end = 1'b0;
        check("dr_idle", in_ready, 1);

        // mask bit 1 now dispatches directly at iteration 1
        in_valid = 1'b1; in_pkt = 32'h0000_080F;
        tick();
        in_valid = 1'b0;
        check("it1_rs", rs_valid, 1);
        check("it1_noreq", Req, 0);
        tick();

        do_replay(32'h4000_0222, 2'd2);
        do_replay(32'h4000_0333, 2'd3);

        // last-iteration barrier
        in_valid = 1'b1; in_pkt = 32'h4000_0444;
        tick();
        in_valid = 1'b0;
        check("last_cd0", cntl_done, 0);
        tick();
        check("last_cd", cntl_done, 1);
        check("last_noreq", Req, 0);
        tick();
        check("last_cd_pulse", cntl_done, 0);
        check("last_iter", replay_Iter, 3);
        check("done_ready", in_ready, 0);
        check("done_tc0", task_complete, 0);
        vertex_done = 1'b1;
        tick();
        vertex_done = 1'b0;
        check("done_tc", task_complete, 1);
        tick(); tick();
        check("done_tc_hold", task_complete, 1);

        // async reset while Req is pending in REPLAY_REQ
        reset = 1'b0;
        tick();
        reset = 1'b1;
        in_valid = 1'b1; in_pkt = 32'h4000_0555;
        tick();
        in_valid = 1'b0;
        tick();
        check("ar_req", Req, 1);
        #3 reset = 1'b0;
        #1;
        check("ar_req0", Req, 0);
        check("ar_tc0", task_complete, 0);
        check("ar_iter0", replay_Iter, 0);
        check("ar_ready0", in_ready, 0);
        check("ar_defer0", defer_cnt, 0);
        tick();
        reset = 1'b1;
        grant = 1'b1;
        #1;
        check("ar_idle_ready", in_ready, 1);
        check("ar_no_mem", mem_valid, 0);
        grant = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
